// File: rtl/dpram_arbiter.sv
// Four-requester arbiter in front of a dual-port RAM. Each cycle a round-robin
// scan picks up to two requesters (port A, port B), defers port B on an
// address/write hazard with port A, and returns registered read responses.
module dpram_arbiter #(
  parameter int unsigned N = 4,  // RAM address width
  parameter int unsigned W = 8   // RAM data width
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [3:0]     REQ,
  input  logic [3:0]     REQ_WE,
  input  logic [4*N-1:0] REQ_ADDR,
  input  logic [4*W-1:0] REQ_WDATA,
  output logic [3:0]     GNT,
  output logic [3:0]     RSP_VALID,
  output logic [4*W-1:0] RSP_RDATA,
  output logic           CS,
  output logic           WR_RD_A,
  output logic           WR_RD_B,
  output logic [N-1:0]   ADDR_A,
  output logic [N-1:0]   ADDR_B,
  output logic [W-1:0]   WDATA_A,
  output logic [W-1:0]   WDATA_B,
  input  logic [W-1:0]   RDATA_A,
  input  logic [W-1:0]   RDATA_B,
  output logic [7:0]     CONFLICT_CNT
);

  logic [1:0] ptr_q, ptr_d;
  logic [3:0] rsp_valid_q, rsp_valid_d;
  logic [3:0] rsp_port_q, rsp_port_d;  // 0: data comes from port A, 1: port B
  logic [7:0] cnt_q, cnt_d;

  logic [N-1:0] addr_arr [4];
  logic [W-1:0] wdata_arr [4];

  logic       a_found, b_found, b_seen, conflict;
  logic [1:0] a_idx, b_idx;
  logic       gnt_a, gnt_b;

  // Split the flat request buses into per-requester fields
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addr_arr[i]  = REQ_ADDR[i*N +: N];
      wdata_arr[i] = REQ_WDATA[i*W +: W];
    end
  end

  // Round-robin scan: first active requester wins A, second is the B candidate
  always_comb begin
    logic [1:0] idx;
    a_found  = 1'b0;
    b_found  = 1'b0;
    b_seen   = 1'b0;
    conflict = 1'b0;
    a_idx    = 2'd0;
    b_idx    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (REQ[idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = idx;
        end else if (!b_seen) begin
          // Only the first candidate is tried for B; a hazard leaves B idle
          b_seen = 1'b1;
          if ((addr_arr[idx] == addr_arr[a_idx]) && (REQ_WE[idx] || REQ_WE[a_idx])) begin
            conflict = 1'b1;
          end else begin
            b_found = 1'b1;
            b_idx   = idx;
          end
        end
      end
    end
  end

  assign gnt_a = a_found & RST_N;
  assign gnt_b = b_found & RST_N;

  // Grants, chip select and RAM port drive
  always_comb begin
    GNT     = 4'd0;
    WR_RD_A = 1'b0;
    WR_RD_B = 1'b0;
    ADDR_A  = '0;
    ADDR_B  = '0;
    WDATA_A = '0;
    WDATA_B = '0;
    if (gnt_a) GNT[a_idx] = 1'b1;
    if (gnt_b) GNT[b_idx] = 1'b1;
    CS = ~(gnt_a | gnt_b);
    if (a_found) begin
      WR_RD_A = REQ_WE[a_idx];
      ADDR_A  = addr_arr[a_idx];
      WDATA_A = wdata_arr[a_idx];
      if (b_found) begin
        WR_RD_B = REQ_WE[b_idx];
        ADDR_B  = addr_arr[b_idx];
        WDATA_B = wdata_arr[b_idx];
      end else begin
        ADDR_B = addr_arr[a_idx];  // idle B reads the same word as A
      end
    end
  end

  // Next pointer, response tags and conflict counter
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = 4'd0;
    rsp_port_d  = 4'd0;
    cnt_d       = cnt_q;
    if (gnt_b) begin
      ptr_d = b_idx + 2'd1;
    end else if (gnt_a) begin
      ptr_d = a_idx + 2'd1;
    end
    if (gnt_a && !REQ_WE[a_idx]) begin
      rsp_valid_d[a_idx] = 1'b1;
      rsp_port_d[a_idx]  = 1'b0;
    end
    if (gnt_b && !REQ_WE[b_idx]) begin
      rsp_valid_d[b_idx] = 1'b1;
      rsp_port_d[b_idx]  = 1'b1;
    end
    if (conflict && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q       <= 2'd0;
      rsp_valid_q <= 4'd0;
      rsp_port_q  <= 4'd0;
      cnt_q       <= 8'd0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_port_q  <= rsp_port_d;
      cnt_q       <= cnt_d;
    end
  end

  // Route RAM read data to the requester that owns each response
  always_comb begin
    RSP_RDATA = '0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid_q[i]) begin
        RSP_RDATA[i*W +: W] = rsp_port_q[i] ? RDATA_B : RDATA_A;
      end
    end
  end

  assign RSP_VALID    = rsp_valid_q;
  assign CONFLICT_CNT = cnt_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: directed scenarios plus randomized traffic checked
// against a scan-list reference model and a behavioural dual-port RAM.
module tb_dpram_arbiter;

  localparam int TN = 4;
  localparam int TW = 8;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [3:0]      REQ, REQ_WE, GNT, RSP_VALID;
  logic [4*TN-1:0] REQ_ADDR;
  logic [4*TW-1:0] REQ_WDATA, RSP_RDATA;
  logic            CS, WR_RD_A, WR_RD_B;
  logic [TN-1:0]   ADDR_A, ADDR_B;
  logic [TW-1:0]   WDATA_A, WDATA_B, RDATA_A, RDATA_B;
  logic [7:0]      CONFLICT_CNT;

  logic [3:0]    t_req = 4'd0, t_we = 4'd0;
  logic [TN-1:0] t_addr [4];
  logic [TW-1:0] t_wd [4];

  int n_vec = 0;
  int n_err = 0;

  dpram_arbiter #(.N(TN), .W(TW)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .GNT(GNT), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
    .CS(CS), .WR_RD_A(WR_RD_A), .WR_RD_B(WR_RD_B), .ADDR_A(ADDR_A), .ADDR_B(ADDR_B),
    .WDATA_A(WDATA_A), .WDATA_B(WDATA_B), .RDATA_A(RDATA_A), .RDATA_B(RDATA_B),
    .CONFLICT_CNT(CONFLICT_CNT)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    REQ    = t_req;
    REQ_WE = t_we;
    for (int i = 0; i < 4; i++) begin
      REQ_ADDR[i*TN +: TN]  = t_addr[i];
      REQ_WDATA[i*TW +: TW] = t_wd[i];
    end
  end

  // Behavioural RAM: registered read, write on the access edge
  logic [TW-1:0] ram [16];
  logic          ram_load = 1'b1;
  logic [TW-1:0] seed;
  always @(posedge CLK) begin
    if (ram_load) begin
      for (int i = 0; i < 16; i++) ram[i] <= TW'(i * 37) ^ seed;
    end else if (!CS) begin
      if (WR_RD_A) ram[ADDR_A] <= WDATA_A;
      else RDATA_A <= ram[ADDR_A];
      if (WR_RD_B) ram[ADDR_B] <= WDATA_B;
      else RDATA_B <= ram[ADDR_B];
    end
  end

  // Reference model state
  int            m_ptr, m_cnt;
  logic [TW-1:0] m_mem [16];
  logic [3:0]    m_rsp_v;
  logic [TW-1:0] m_rsp_d [4];
  // Model expectations for the current cycle
  int            e_a, e_b;
  bit            e_conf;
  logic [3:0]    e_gnt;
  logic          e_wr_a, e_wr_b;
  logic [TN-1:0] e_addr_a, e_addr_b;
  logic [TW-1:0] e_wd_a, e_wd_b;

  function automatic void model_reset();
    m_ptr = 0;
    m_cnt = 0;
    m_rsp_v = 4'd0;
    for (int i = 0; i < 4; i++) m_rsp_d[i] = '0;
  endfunction

  // List active requesters in round-robin order, then take the first two
  function automatic void model_eval();
    int order[$];
    order = {};
    for (int k = 0; k < 4; k++) if (t_req[(m_ptr + k) % 4]) order.push_back((m_ptr + k) % 4);
    e_a = -1; e_b = -1; e_conf = 0; e_gnt = 4'd0;
    e_wr_a = 0; e_wr_b = 0; e_addr_a = '0; e_addr_b = '0; e_wd_a = '0; e_wd_b = '0;
    if (order.size() > 0) e_a = order[0];
    if (order.size() > 1) begin
      if (t_addr[order[1]] == t_addr[e_a] && (t_we[e_a] || t_we[order[1]])) e_conf = 1;
      else e_b = order[1];
    end
    if (e_a >= 0) begin
      e_gnt[e_a] = 1'b1;
      e_wr_a = t_we[e_a]; e_addr_a = t_addr[e_a]; e_wd_a = t_wd[e_a];
      e_addr_b = t_addr[e_a];
    end
    if (e_b >= 0) begin
      e_gnt[e_b] = 1'b1;
      e_wr_b = t_we[e_b]; e_addr_b = t_addr[e_b]; e_wd_b = t_wd[e_b];
    end
  endfunction

  function automatic void model_commit();
    m_rsp_v = 4'd0;
    for (int i = 0; i < 4; i++) m_rsp_d[i] = '0;
    if (e_a >= 0 && !t_we[e_a]) begin m_rsp_v[e_a] = 1'b1; m_rsp_d[e_a] = m_mem[t_addr[e_a]]; end
    if (e_b >= 0 && !t_we[e_b]) begin m_rsp_v[e_b] = 1'b1; m_rsp_d[e_b] = m_mem[t_addr[e_b]]; end
    if (e_a >= 0 && t_we[e_a]) m_mem[t_addr[e_a]] = t_wd[e_a];
    if (e_b >= 0 && t_we[e_b]) m_mem[t_addr[e_b]] = t_wd[e_b];
    if (e_conf && m_cnt < 255) m_cnt++;
    if (e_b >= 0) m_ptr = (e_b + 1) % 4;
    else if (e_a >= 0) m_ptr = (e_a + 1) % 4;
  endfunction

  task automatic advance();
    @(posedge CLK);
    model_commit();
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input int addr, input logic [TW-1:0] wd);
    t_req[i] = 1'b1; t_we[i] = we; t_addr[i] = TN'(addr); t_wd[i] = wd;
  endtask

  task automatic test_reset();
    t_req = 4'b1111; t_we = 4'd0;
    for (int i = 0; i < 4; i++) begin t_addr[i] = TN'(i); t_wd[i] = '0; end
    @(posedge CLK);
    #1 RST_N = 1'b0;
    #2;
    n_vec += 4;
    if (GNT !== 4'd0) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", GNT); end
    if (CS !== 1'b1) begin n_err++; $display("FAIL reset_cs: got %b want 1", CS); end
    if (RSP_VALID !== 4'd0) begin n_err++; $display("FAIL reset_rsp: got %b want 0000", RSP_VALID); end
    if (CONFLICT_CNT !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", CONFLICT_CNT); end
    model_reset();
    @(negedge CLK);
    t_req = 4'd0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_two_reads();
    test_reset();
    set_req(0, 1'b0, 3, 8'h00); set_req(2, 1'b0, 7, 8'h00);
    @(negedge CLK); model_eval();
    n_vec += 3;
    if (GNT !== 4'b0101) begin n_err++; $display("FAIL two_reads_gnt: got %b want 0101", GNT); end
    if (ADDR_A !== TN'(3)) begin n_err++; $display("FAIL two_reads_addr_a: got %0d want 3", ADDR_A); end
    if (ADDR_B !== TN'(7)) begin n_err++; $display("FAIL two_reads_addr_b: got %0d want 7", ADDR_B); end
    advance();
    t_req = 4'd0;
    @(negedge CLK); model_eval();
    n_vec += 3;
    if (RSP_VALID !== 4'b0101) begin n_err++; $display("FAIL two_reads_rsp: got %b want 0101", RSP_VALID); end
    if (RSP_RDATA[0 +: TW] !== m_mem[3]) begin
      n_err++; $display("FAIL two_reads_d0: got %h want %h", RSP_RDATA[0 +: TW], m_mem[3]);
    end
    if (RSP_RDATA[2*TW +: TW] !== m_mem[7]) begin
      n_err++; $display("FAIL two_reads_d2: got %h want %h", RSP_RDATA[2*TW +: TW], m_mem[7]);
    end
    advance();
    // Pointer now at 3: requesters 3 and 0 win
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, i + 8, 8'h00);
    @(negedge CLK); model_eval();
    n_vec++;
    if (GNT !== 4'b1001) begin n_err++; $display("FAIL two_reads_ptr: got %b want 1001", GNT); end
    advance();
    t_req = 4'd0;
  endtask

  task automatic test_conflict();
    test_reset();
    set_req(1, 1'b1, 5, 8'hA5); set_req(2, 1'b0, 5, 8'h00);
    @(negedge CLK); model_eval();
    n_vec += 2;
    if (GNT !== 4'b0010) begin n_err++; $display("FAIL conflict_gnt: got %b want 0010", GNT); end
    if (WR_RD_A !== 1'b1) begin n_err++; $display("FAIL conflict_we_a: got %b want 1", WR_RD_A); end
    advance();
    t_req[1] = 1'b0;
    @(negedge CLK); model_eval();
    n_vec += 2;
    if (CONFLICT_CNT !== 8'd1) begin n_err++; $display("FAIL conflict_cnt: got %0d want 1", CONFLICT_CNT); end
    if (GNT !== 4'b0100) begin n_err++; $display("FAIL conflict_retry: got %b want 0100", GNT); end
    advance();
    t_req = 4'd0;
    @(negedge CLK); model_eval();
    n_vec += 2;
    if (RSP_VALID !== 4'b0100) begin n_err++; $display("FAIL conflict_rsp: got %b want 0100", RSP_VALID); end
    if (RSP_RDATA[2*TW +: TW] !== 8'hA5) begin
      n_err++; $display("FAIL conflict_data: got %h want a5", RSP_RDATA[2*TW +: TW]);
    end
    advance();
  endtask

  task automatic test_idle();
    // Pointer is 3 after the conflict scenario
    t_req = 4'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK); model_eval();
      n_vec += 3;
      if (CS !== 1'b1) begin n_err++; $display("FAIL idle_cs: got %b want 1", CS); end
      if (GNT !== 4'd0) begin n_err++; $display("FAIL idle_gnt: got %b want 0000", GNT); end
      if (RSP_VALID !== 4'd0) begin n_err++; $display("FAIL idle_rsp: got %b want 0000", RSP_VALID); end
      advance();
    end
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, i, 8'h00);
    @(negedge CLK); model_eval();
    n_vec++;
    if (GNT !== 4'b1001) begin n_err++; $display("FAIL idle_ptr_hold: got %b want 1001", GNT); end
    advance();
    t_req = 4'd0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_tab [4];
    int pulses = 0;
    exp_tab = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
    test_reset();
    for (int c = 0; c < 5; c++) begin
      if (c < 4) for (int i = 0; i < 4; i++) set_req(i, 1'b0, i + 4, 8'h00);
      else t_req = 4'd0;
      @(negedge CLK); model_eval();
      if (c < 4) begin
        n_vec++;
        if (GNT !== exp_tab[c]) begin
          n_err++; $display("FAIL b2b_gnt%0d: got %b want %b", c, GNT, exp_tab[c]);
        end
      end
      pulses += $countones(RSP_VALID);
      advance();
    end
    n_vec++;
    if (pulses != 8) begin n_err++; $display("FAIL b2b_pulses: got %0d want 8", pulses); end
  endtask

  task automatic test_saturate();
    test_reset();
    set_req(0, 1'b1, 1, 8'h11); set_req(1, 1'b0, 1, 8'h00);
    for (int c = 0; c < 260; c++) begin
      @(negedge CLK); model_eval();
      advance();
    end
    t_req = 4'd0;
    @(negedge CLK); model_eval();
    n_vec++;
    if (CONFLICT_CNT !== 8'd255) begin n_err++; $display("FAIL saturate: got %0d want 255", CONFLICT_CNT); end
    advance();
  endtask

  task automatic test_reset_mid();
    test_reset();
    set_req(0, 1'b1, 2, 8'h3C); set_req(1, 1'b0, 2, 8'h00);
    @(negedge CLK); model_eval(); advance();
    t_req[0] = 1'b0;
    @(negedge CLK); model_eval();
    n_vec += 2;
    if (CONFLICT_CNT !== 8'd1) begin n_err++; $display("FAIL mid_cnt_pre: got %0d want 1", CONFLICT_CNT); end
    if (GNT !== 4'b0010) begin n_err++; $display("FAIL mid_read_gnt: got %b want 0010", GNT); end
    advance();
    t_req = 4'd0;
    #2 RST_N = 1'b0;
    #1;
    n_vec++;
    if (RSP_VALID !== 4'd0) begin n_err++; $display("FAIL mid_rsp_drop: got %b want 0000", RSP_VALID); end
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, i, 8'h00);
    @(negedge CLK); model_eval();
    n_vec += 3;
    if (CONFLICT_CNT !== 8'd0) begin n_err++; $display("FAIL mid_cnt_post: got %0d want 0", CONFLICT_CNT); end
    if (GNT !== 4'b0011) begin n_err++; $display("FAIL mid_ptr_post: got %b want 0011", GNT); end
    if (RSP_VALID !== 4'd0) begin n_err++; $display("FAIL mid_no_replay: got %b want 0000", RSP_VALID); end
    advance();
    t_req = 4'd0;
  endtask

  task automatic test_random();
    test_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!t_req[i] && $urandom_range(0, 3) != 0) begin
          set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3), TW'($urandom));
        end
      end
      @(negedge CLK); model_eval();
      n_vec += 12;
      if (GNT !== e_gnt) begin n_err++; $display("FAIL rnd_gnt@%0d: got %b want %b", c, GNT, e_gnt); end
      if (CS !== (e_gnt == 4'd0)) begin n_err++; $display("FAIL rnd_cs@%0d: got %b", c, CS); end
      if (WR_RD_A !== e_wr_a) begin n_err++; $display("FAIL rnd_we_a@%0d: got %b want %b", c, WR_RD_A, e_wr_a); end
      if (WR_RD_B !== e_wr_b) begin n_err++; $display("FAIL rnd_we_b@%0d: got %b want %b", c, WR_RD_B, e_wr_b); end
      if (ADDR_A !== e_addr_a) begin n_err++; $display("FAIL rnd_addr_a@%0d: got %0d want %0d", c, ADDR_A, e_addr_a); end
      if (ADDR_B !== e_addr_b) begin n_err++; $display("FAIL rnd_addr_b@%0d: got %0d want %0d", c, ADDR_B, e_addr_b); end
      if (WDATA_A !== e_wd_a) begin n_err++; $display("FAIL rnd_wd_a@%0d: got %h want %h", c, WDATA_A, e_wd_a); end
      if (WDATA_B !== e_wd_b) begin n_err++; $display("FAIL rnd_wd_b@%0d: got %h want %h", c, WDATA_B, e_wd_b); end
      if (RSP_VALID !== m_rsp_v) begin n_err++; $display("FAIL rnd_rsp@%0d: got %b want %b", c, RSP_VALID, m_rsp_v); end
      if (CONFLICT_CNT !== 8'(m_cnt)) begin
        n_err++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", c, CONFLICT_CNT, m_cnt);
      end
      for (int i = 0; i < 4; i++) begin
        if (i < 2 || m_rsp_v[i]) begin
          if (RSP_RDATA[i*TW +: TW] !== m_rsp_d[i]) begin
            n_err++; $display("FAIL rnd_rdata%0d@%0d: got %h want %h", i, c, RSP_RDATA[i*TW +: TW], m_rsp_d[i]);
          end
        end
      end
      advance();
      for (int i = 0; i < 4; i++) if (e_gnt[i]) t_req[i] = 1'b0;
    end
    t_req = 4'd0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin t_addr[i] = '0; t_wd[i] = '0; end
    seed = TW'($urandom);
    @(posedge CLK);
    #1 ram_load = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = TW'(i * 37) ^ seed;
    test_reset();
    test_two_reads();
    test_conflict();
    test_idle();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
